// File: rtl/dct_quant_serializer.sv
// Purpose : quantize the eight DCT coefficients by 2^qshift and stream them out in index order.
// Latency : accept edge N -> QUANT until edge N+1 -> out_valid with idx 0 from edge N+1; one vector every 10 cycles at best.
// Backpr. : valid/ready on the output; in_ready only in IDLE, so the upstream vector is held until the previous one has fully drained.
//
// Ports:
//   clk, clr            clock and synchronous active-high clear (priority over everything)
//   in_valid/in_ready   parallel input handshake for coef_in (8 x IN_W signed, G0 in the LSBs) and qshift
//   out_valid/out_ready serial output handshake; out_data (signed OUT_W), out_idx (0..7), out_last (idx 7)
//   nz_count            nonzero entries of the current quantized vector, valid from the first out_valid
module dct_quant_serializer #(
    parameter int IN_W      = 40,
    parameter int FRAC_BITS = 20,
    parameter int OUT_W     = 12,
    parameter int QS_W      = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    coef_in,
    input  logic [QS_W-1:0]      qshift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [2:0]           out_idx,
    output logic                 out_last,
    output logic [3:0]           nz_count
);

    // Wide enough for FRAC_BITS + max qshift.
    localparam int SH_W = $clog2(FRAC_BITS + (1 << QS_W)) + 1;

    // Saturation limits expressed in the IN_W+1 intermediate width.
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUANT = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [8*IN_W-1:0]     r_coef;
    logic [QS_W-1:0]       r_qshift;
    logic [OUT_W-1:0]      r_bank [8];
    logic [2:0]            r_idx;
    logic [3:0]            r_nz;

    logic                  w_accept;
    logic                  w_hs;
    logic [SH_W-1:0]       w_sh;
    logic signed [IN_W:0]  w_round;
    logic signed [IN_W:0]  w_x [8];
    logic signed [IN_W:0]  w_y [8];
    logic [OUT_W-1:0]      w_q [8];
    logic [3:0]            w_nz;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        out_idx   = r_idx;
        nz_count  = r_nz;

        case (r_state)
            S_IDLE: begin
                in_ready = ~clr;
                if (in_valid) begin
                    w_next = S_QUANT;
                end
            end
            S_QUANT: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = r_bank[r_idx];
                out_last  = (r_idx == 3'd7);
                if (out_ready && (r_idx == 3'd7)) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign w_hs     = (r_state == S_SEND) & out_ready;

    // ------------------------------------------------------------------
    // Quantizer: round-half-up then arithmetic shift, in IN_W+1 bits so
    // adding the half-step to the largest positive input cannot wrap.
    // ------------------------------------------------------------------
    always_comb begin
        w_sh    = SH_W'(FRAC_BITS) + SH_W'(r_qshift);
        w_round = (IN_W+1)'(1) << (w_sh - SH_W'(1));
        w_x     = '{default: '0};
        w_y     = '{default: '0};
        w_q     = '{default: '0};
        w_nz    = '0;
        for (int k = 0; k < 8; k++) begin
            w_x[k] = {r_coef[IN_W*k+IN_W-1], r_coef[IN_W*k +: IN_W]};
            w_y[k] = (w_x[k] + w_round) >>> w_sh;
            if (w_y[k] > SAT_MAX) begin
                w_q[k] = SAT_MAX[OUT_W-1:0];
            end else if (w_y[k] < SAT_MIN) begin
                w_q[k] = SAT_MIN[OUT_W-1:0];
            end else begin
                w_q[k] = w_y[k][OUT_W-1:0];
            end
            if (w_q[k] != '0) begin
                w_nz = w_nz + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture, result bank and output index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_coef   <= '0;
            r_qshift <= '0;
            r_bank   <= '{default: '0};
            r_idx    <= '0;
            r_nz     <= '0;
        end else begin
            if (w_accept) begin
                r_coef   <= coef_in;
                r_qshift <= qshift;
            end
            if (r_state == S_QUANT) begin
                r_bank <= w_q;
                r_nz   <= w_nz;
                r_idx  <= '0;
            end
            // Wraps 7 -> 0 on the final handshake, leaving idx 0 in IDLE.
            if (w_hs) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

endmodule
